// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Each instruction goes through FETCH, DECODE, EXEC (R-type/BEQ only) and WB.
module multicycle_controller #(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instruction,
  input  logic             alu_zero,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE, K_BEQ, K_NOP, K_HALT, K_ILL
  } kind_t;

  state_t            state;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  kind_t             ir_kind;
  logic [2:0]        fetch_op;

  function automatic kind_t kind_of(input logic [31:0] w);
    kind_t k;
    k = K_ILL;
    if (w == 32'h0000_003F) k = K_HALT;
    else if (w == 32'h0000_0037) k = K_NOP;
    else if (w[31:26] == 6'b000000) begin
      case (w[5:0])
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: k = K_RTYPE;
        default: k = K_ILL;
      endcase
    end else if (w[31:26] == 6'b000100) k = K_BEQ;
    return k;
  endfunction

  // Unsupported words map to 000, which is also the NOP/HALT value.
  function automatic logic [2:0] op_of(input logic [31:0] w);
    logic [2:0] op;
    op = 3'b000;
    if (w[31:26] == 6'b000000) begin
      case (w[5:0])
        6'b100010: op = 3'b001;
        6'b100100: op = 3'b010;
        6'b100101: op = 3'b011;
        6'b101010: op = 3'b111;
        default:   op = 3'b000;
      endcase
    end else if (w[31:26] == 6'b000100) op = 3'b001;
    return op;
  endfunction

  assign ir_kind  = kind_of(ir);
  assign fetch_op = op_of(instruction);

  // The only combinational output: IR load coincides with the ready cycle.
  assign ir_load = (state == S_FETCH) && imem_ready;

  // Outputs are registered for the state being entered, so they are Moore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= '0;
      wait_cnt    <= '0;
      imem_req    <= 1'b0;
      pc_en       <= 1'b0;
      pc_sel      <= 1'b0;
      alu_op      <= 3'b000;
      reg_we      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      fetch_err   <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state    <= S_DECODE;
            ir       <= instruction;
            alu_op   <= fetch_op;
            imem_req <= 1'b0;
          end else if (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1)) begin
            state     <= S_ERROR;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          case (ir_kind)
            K_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
              alu_op <= 3'b000;
            end
            K_RTYPE, K_BEQ: state <= S_EXEC;
            K_NOP: begin
              state <= S_WB;
              pc_en <= 1'b1;
            end
            default: begin
              state   <= S_WB;
              pc_en   <= 1'b1;
              illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          state  <= S_WB;
          pc_en  <= 1'b1;
          pc_sel <= (ir_kind == K_BEQ) && alu_zero;
          reg_we <= (ir_kind == K_RTYPE) && (ir[15:11] != 5'd0);
        end
        S_WB: begin
          state    <= S_FETCH;
          pc_en    <= 1'b0;
          pc_sel   <= 1'b0;
          reg_we   <= 1'b0;
          alu_op   <= 3'b000;
          imem_req <= 1'b1;
          wait_cnt <= '0;
          if (instr_count != {CNT_W{1'b1}}) instr_count <= instr_count + 1'b1;
        end
        S_HALT, S_ERROR: state <= state;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed scenarios plus a random
// instruction stream checked against a per-instruction behavioural model.
module tb_multicycle_controller;

  localparam int CNT_W = 4;
  localparam int TO    = 15;
  localparam logic [31:0] ADD_W  = 32'h0022_1820;
  localparam logic [31:0] SUB_W  = 32'h0022_1822;
  localparam logic [31:0] ADD0_W = 32'h0022_0020;
  localparam logic [31:0] BEQ_W  = 32'h1022_0003;
  localparam logic [31:0] NOP_W  = 32'h0000_0037;
  localparam logic [31:0] HALT_W = 32'h0000_003F;
  localparam logic [31:0] LW_W   = 32'h8C22_0000;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, imem_ready = 1'b0, alu_zero = 1'b0;
  logic [31:0] instruction = '0;
  logic imem_req, ir_load, pc_en, pc_sel, reg_we, busy, halted, illegal, fetch_err;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] instr_count;

  multicycle_controller #(.CNT_W(CNT_W), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ready(imem_ready),
    .instruction(instruction), .alu_zero(alu_zero), .ir_load(ir_load), .pc_en(pc_en),
    .pc_sel(pc_sel), .alu_op(alu_op), .reg_we(reg_we), .busy(busy), .halted(halted),
    .illegal(illegal), .fetch_err(fetch_err), .instr_count(instr_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected alu_op for every post-fetch cycle of an instruction
  logic [2:0] exp_q[$];
  logic [2:0] obs_ops[$];

  // Observations collected by run_instr
  int o_req, o_irl, o_pc_en, o_we, o_sel, o_stray, o_fin;
  logic [CNT_W-1:0] o_count;
  logic o_illegal;

  function automatic logic [11+CNT_W:0] all_outs();
    return {imem_req, ir_load, pc_en, pc_sel, alu_op, reg_we, busy, halted,
            illegal, fetch_err, instr_count};
  endfunction

  // Behavioural model. kind: 0 R-type, 1 BEQ, 2 NOP, 3 HALT, 4 illegal.
  function automatic void model(input logic [31:0] w, output int kind, output logic [2:0] op);
    kind = 4;
    op   = 3'b000;
    if (w == HALT_W) kind = 3;
    else if (w == NOP_W) kind = 2;
    else if (w[31:26] == 6'd0) begin
      case (int'(w[5:0]))
        32: begin kind = 0; op = 3'd0; end
        34: begin kind = 0; op = 3'd1; end
        36: begin kind = 0; op = 3'd2; end
        37: begin kind = 0; op = 3'd3; end
        42: begin kind = 0; op = 3'd7; end
        default: kind = 4;
      endcase
    end else if (w[31:26] == 6'd4) begin
      kind = 1;
      op   = 3'd1;
    end
  endfunction

  // Drivers
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ready = 1'b0; instruction = '0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    imem_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle to WB, HALT or ERROR.
  // Outside FETCH, start/imem_ready/instruction are randomised to show they are ignored.
  task automatic run_instr(input logic [31:0] w, input int wait_n, input logic zero);
    int fc;
    fc = 0;
    o_req = 0; o_irl = 0; o_pc_en = 0; o_we = 0; o_sel = 0; o_stray = 0; o_fin = 3;
    obs_ops.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      alu_zero    = zero;
      start       = 1'($urandom_range(0, 1));
      instruction = imem_req ? w : $urandom;
      imem_ready  = imem_req ? (fc >= wait_n) : 1'($urandom_range(0, 1));
      #1;
      if (halted) begin o_fin = 1; break; end
      if (fetch_err) begin o_fin = 2; break; end
      if (!busy || (ir_load && (pc_en || reg_we))) o_stray++;
      if (imem_req) begin
        o_req++;
        if (pc_en || reg_we || alu_op != 3'd0) o_stray++;
        if (ir_load) o_irl++;
        else fc++;
      end else begin
        obs_ops.push_back(alu_op);
        if (pc_en)  o_pc_en++;
        if (reg_we) o_we++;
        if (pc_sel) o_sel++;
        if (pc_en) begin o_fin = 0; break; end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    imem_ready = 1'b0;
    o_count = instr_count;
    o_illegal = illegal;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_during: outputs %h expected 0", all_outs()); end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_idle[%0d]: outputs %h expected 0", i, all_outs()); end
    end
  endtask

  task automatic test_add();
    do_reset();
    do_start();
    run_instr(ADD_W, 0, 1'b0);
    n_checks++; if (o_fin !== 0) begin n_fail++; $display("FAIL add_end: got %0d expected 0", o_fin); end
    n_checks++; if (o_req !== 1 || o_irl !== 1) begin n_fail++; $display("FAIL add_fetch: req %0d irl %0d expected 1 1", o_req, o_irl); end
    n_checks++; if (obs_ops.size() !== 3) begin n_fail++; $display("FAIL add_cycles: got %0d expected 3", obs_ops.size()); end
    foreach (obs_ops[i]) begin
      n_checks++; if (obs_ops[i] !== 3'b000) begin n_fail++; $display("FAIL add_alu_op[%0d]: got %b expected 000", i, obs_ops[i]); end
    end
    n_checks++; if (o_pc_en !== 1 || o_we !== 1 || o_sel !== 0) begin n_fail++; $display("FAIL add_wb: pc_en %0d we %0d sel %0d expected 1 1 0", o_pc_en, o_we, o_sel); end
    n_checks++; if (o_count !== 1) begin n_fail++; $display("FAIL add_count: got %0d expected 1", o_count); end
    n_checks++; if (o_stray !== 0) begin n_fail++; $display("FAIL add_stray: got %0d expected 0", o_stray); end
  endtask

  task automatic test_wait_states();
    do_reset();
    do_start();
    run_instr(ADD_W, 3, 1'b0);
    n_checks++; if (o_req !== 4 || o_irl !== 1 || o_fin !== 0) begin n_fail++; $display("FAIL wait3: req %0d irl %0d end %0d expected 4 1 0", o_req, o_irl, o_fin); end
    run_instr(SUB_W, TO - 1, 1'b0);
    n_checks++; if (o_req !== TO || o_fin !== 0 || o_count !== 2) begin n_fail++; $display("FAIL wait_max: req %0d end %0d count %0d expected %0d 0 2", o_req, o_fin, o_count, TO); end
    run_instr(ADD_W, TO, 1'b0);
    n_checks++; if (o_fin !== 2 || o_req !== TO) begin n_fail++; $display("FAIL timeout: end %0d req %0d expected 2 %0d", o_fin, o_req, TO); end
    repeat (3) @(negedge clk);
    n_checks++; if ({fetch_err, busy, imem_req, pc_en} !== 4'b1000) begin n_fail++; $display("FAIL err_state: err/busy/req/pc_en %b expected 1000", {fetch_err, busy, imem_req, pc_en}); end
  endtask

  task automatic test_beq();
    do_reset();
    do_start();
    run_instr(BEQ_W, 0, 1'b1);
    n_checks++; if (o_sel !== 1 || o_we !== 0 || o_pc_en !== 1 || obs_ops.size() !== 3) begin n_fail++; $display("FAIL beq_taken: sel %0d we %0d pc_en %0d cyc %0d expected 1 0 1 3", o_sel, o_we, o_pc_en, obs_ops.size()); end
    n_checks++; if (obs_ops[0] !== 3'b001) begin n_fail++; $display("FAIL beq_op: got %b expected 001", obs_ops[0]); end
    run_instr(BEQ_W, 1, 1'b0);
    n_checks++; if (o_sel !== 0 || o_we !== 0 || o_pc_en !== 1) begin n_fail++; $display("FAIL beq_not_taken: sel %0d we %0d pc_en %0d expected 0 0 1", o_sel, o_we, o_pc_en); end
  endtask

  task automatic test_exceptional();
    do_reset();
    do_start();
    run_instr(NOP_W, 0, 1'b0);
    n_checks++; if (obs_ops.size() !== 2 || o_we !== 0 || o_pc_en !== 1 || o_count !== 1 || o_illegal !== 0) begin n_fail++; $display("FAIL nop: cyc %0d we %0d pc_en %0d count %0d ill %0d expected 2 0 1 1 0", obs_ops.size(), o_we, o_pc_en, o_count, o_illegal); end
    run_instr(LW_W, 2, 1'b0);
    n_checks++; if (o_illegal !== 1 || o_pc_en !== 1 || o_we !== 0 || obs_ops.size() !== 2 || o_count !== 2) begin n_fail++; $display("FAIL illegal: ill %0d pc_en %0d we %0d cyc %0d count %0d expected 1 1 0 2 2", o_illegal, o_pc_en, o_we, obs_ops.size(), o_count); end
    run_instr(ADD0_W, 0, 1'b0);
    n_checks++; if (o_we !== 0 || o_pc_en !== 1 || o_illegal !== 1) begin n_fail++; $display("FAIL add_rd0: we %0d pc_en %0d ill %0d expected 0 1 1", o_we, o_pc_en, o_illegal); end
    run_instr(HALT_W, 0, 1'b0);
    n_checks++; if (o_fin !== 1 || o_pc_en !== 0 || o_count !== 3) begin n_fail++; $display("FAIL halt: end %0d pc_en %0d count %0d expected 1 0 3", o_fin, o_pc_en, o_count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1; imem_ready = 1'b1;
      #1;
      n_checks++; if ({halted, busy, imem_req, pc_en, reg_we} !== 5'b10000) begin n_fail++; $display("FAIL halt_hold[%0d]: got %b expected 10000", i, {halted, busy, imem_req, pc_en, reg_we}); end
    end
    start = 1'b0; imem_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    do_reset();
    do_start();
    @(negedge clk);
    instruction = ADD_W; imem_ready = 1'b1;
    @(posedge clk);
    #1 imem_ready = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL rst_exec: outputs %h expected 0", all_outs()); end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if ({pc_en, reg_we, imem_req, busy, instr_count} !== '0) begin n_fail++; $display("FAIL rst_exec_after[%0d]: got %b expected 0", i, {pc_en, reg_we, imem_req, busy, instr_count}); end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int f;
    w = $urandom;
    f = $urandom_range(0, 4);
    case ($urandom_range(0, 5))
      0: w = {6'd0, w[25:6], 6'(f == 0 ? 32 : f == 1 ? 34 : f == 2 ? 36 : f == 3 ? 37 : 42)};
      1: w = {6'd0, w[25:0]};
      2: w = {6'd4, w[25:0]};
      3: w = NOP_W;
      4: w = w;
      default: w = {6'd0, w[25:16], 5'd0, 5'd0, 6'd32};
    endcase
    return w;
  endfunction

  task automatic test_random();
    int kind, exp_count, exp_post;
    logic [2:0] op, e, got;
    logic [31:0] w;
    logic zero, exp_ill;
    exp_count = 0;
    exp_ill = 1'b0;
    do_reset();
    do_start();
    for (int n = 0; n < 41; n++) begin
      w = (n == 40) ? HALT_W : rand_instr();
      zero = 1'($urandom_range(0, 1));
      model(w, kind, op);
      exp_post = (kind <= 1) ? 3 : (kind == 3) ? 1 : 2;
      repeat (exp_post) exp_q.push_back(op);
      if (kind == 4) exp_ill = 1'b1;
      if (kind != 3) exp_count = (exp_count + 1 > 15) ? 15 : exp_count + 1;
      run_instr(w, $urandom_range(0, 4), zero);
      n_checks++; if (o_fin !== ((kind == 3) ? 1 : 0) || o_irl !== 1) begin n_fail++; $display("FAIL rnd_end[%0d] %h: end %0d irl %0d expected %0d 1", n, w, o_fin, o_irl, (kind == 3) ? 1 : 0); end
      n_checks++; if (obs_ops.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_cycles[%0d] %h: got %0d expected %0d", n, w, obs_ops.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = (obs_ops.size() > 0) ? obs_ops.pop_front() : 3'bxxx;
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL rnd_alu_op[%0d] %h: got %b expected %b", n, w, got, e); end
      end
      n_checks++; if (o_pc_en !== ((kind == 3) ? 0 : 1) || o_we !== ((kind == 0 && w[15:11] != 0) ? 1 : 0) || o_sel !== ((kind == 1 && zero) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_wb[%0d] %h: pc_en %0d we %0d sel %0d", n, w, o_pc_en, o_we, o_sel); end
      n_checks++; if (o_count !== CNT_W'(exp_count) || o_illegal !== exp_ill || o_stray !== 0) begin n_fail++; $display("FAIL rnd_state[%0d] %h: count %0d ill %0d stray %0d expected %0d %0d 0", n, w, o_count, o_illegal, o_stray, exp_count, exp_ill); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wait_states();
    test_beq();
    test_exceptional();
    test_reset_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
